// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage with PC, imem ready/req handshake, one-entry skid
// buffer for fetches that land during a stall, branch redirect, and the IF/ID
// pipeline register feeding the hazard detection unit.
module fetch_stage #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [3:0]         opCode,
  output logic [3:0]         RAddr1,
  output logic [3:0]         RAddr2
);

  localparam int unsigned FIELD_W = 4;

  typedef enum logic [1:0] {IDLE, REQ, BUF} stateT;

  stateT               stateQ, stateD;
  logic [PC_W-1:0]     pcQ, pcD;
  logic                dropQ, dropD;
  logic [PC_W-1:0]     redirQ, redirD;
  logic [INSTR_W-1:0]  bufInstrQ, bufInstrD;
  logic [PC_W-1:0]     bufPcQ, bufPcD;
  logic                idValidQ, idValidD;
  logic [INSTR_W-1:0]  idInstrQ, idInstrD;
  logic [PC_W-1:0]     idPcQ, idPcD;

  logic                deliver;
  logic [INSTR_W-1:0]  delInstr;
  logic [PC_W-1:0]     delPc;

  // State and pipeline registers; reset aborts any fetch in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      pcQ       <= RESET_PC;
      dropQ     <= 1'b0;
      redirQ    <= '0;
      bufInstrQ <= '0;
      bufPcQ    <= '0;
      idValidQ  <= 1'b0;
      idInstrQ  <= '0;
      idPcQ     <= '0;
    end else begin
      stateQ    <= stateD;
      pcQ       <= pcD;
      dropQ     <= dropD;
      redirQ    <= redirD;
      bufInstrQ <= bufInstrD;
      bufPcQ    <= bufPcD;
      idValidQ  <= idValidD;
      idInstrQ  <= idInstrD;
      idPcQ     <= idPcD;
    end
  end

  // Next-state: fetch FSM, redirect handling, then IF/ID update priority
  always_comb begin
    stateD    = stateQ;
    pcD       = pcQ;
    dropD     = dropQ;
    redirD    = redirQ;
    bufInstrD = bufInstrQ;
    bufPcD    = bufPcQ;
    idValidD  = idValidQ;
    idInstrD  = idInstrQ;
    idPcD     = idPcQ;
    deliver   = 1'b0;
    delInstr  = imem_rdata;
    delPc     = pcQ;

    case (stateQ)
      IDLE: begin
        stateD = REQ;
        if (branch_taken) pcD = branch_target;
      end
      REQ: begin
        if (!imem_ready) begin
          // Address must stay put until the memory answers; remember the redirect
          if (branch_taken) begin
            dropD  = 1'b1;
            redirD = branch_target;
          end
        end else if (branch_taken) begin
          pcD   = branch_target;
          dropD = 1'b0;
        end else if (dropQ) begin
          pcD   = redirQ;
          dropD = 1'b0;
        end else if (stall) begin
          bufInstrD = imem_rdata;
          bufPcD    = pcQ;
          pcD       = pcQ + PC_W'(1);
          stateD    = BUF;
        end else begin
          deliver  = 1'b1;
          delInstr = imem_rdata;
          delPc    = pcQ;
          pcD      = pcQ + PC_W'(1);
        end
      end
      BUF: begin
        if (branch_taken) begin
          pcD    = branch_target;
          stateD = REQ;
        end else if (!stall) begin
          deliver  = 1'b1;
          delInstr = bufInstrQ;
          delPc    = bufPcQ;
          stateD   = REQ;
        end
      end
      default: stateD = IDLE;
    endcase

    // Flush beats stall; stall holds; otherwise load or insert a bubble
    if (branch_taken) begin
      idValidD = 1'b0;
    end else if (stall) begin
      idValidD = idValidQ;
    end else if (deliver) begin
      idValidD = 1'b1;
      idInstrD = delInstr;
      idPcD    = delPc;
    end else begin
      idValidD = 1'b0;
    end
  end

  assign imem_req  = (stateQ == REQ);
  assign imem_addr = pcQ;
  assign id_valid  = idValidQ;
  assign id_instr  = idInstrQ;
  assign id_pc     = idPcQ;

  // Bubbles decode to a harmless pattern so the hazard unit never stalls on them
  assign opCode = idValidQ ? idInstrQ[15:12] : 4'hF;
  assign RAddr1 = idValidQ ? idInstrQ[7:4]   : FIELD_W'(0);
  assign RAddr2 = idValidQ ? idInstrQ[3:0]   : FIELD_W'(0);

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Directed bench for fetch_stage: stimulus pushes expected IF/ID contents into
// a queue, monitors pop and compare whenever a new instruction is presented.
module tb_fetch_stage;

  localparam int unsigned PC_W    = 16;
  localparam int unsigned INSTR_W = 16;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               stall, branch_taken, imem_ready;
  logic [PC_W-1:0]    branch_target;
  logic               imem_req, id_valid;
  logic [PC_W-1:0]    imem_addr, id_pc;
  logic [INSTR_W-1:0] imem_rdata, id_instr;
  logic [3:0]         opCode, RAddr1, RAddr2;

  logic               wStall, wBranch, wReady;
  logic [PC_W-1:0]    wTarget;
  logic               wReq, wValid;
  logic [PC_W-1:0]    wAddr, wPc;
  logic [INSTR_W-1:0] wRdata, wInstr;
  logic [3:0]         wOp, wR1, wR2;

  // Memory model: instruction at address A is 0x1000 + A
  assign imem_rdata = 16'h1000 + imem_addr;
  assign wRdata     = 16'h1000 + wAddr;

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .opCode(opCode), .RAddr1(RAddr1),
    .RAddr2(RAddr2));

  fetch_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall(wStall), .branch_taken(wBranch),
    .branch_target(wTarget), .imem_req(wReq), .imem_addr(wAddr),
    .imem_rdata(wRdata), .imem_ready(wReady), .id_valid(wValid),
    .id_instr(wInstr), .id_pc(wPc), .opCode(wOp), .RAddr1(wR1), .RAddr2(wR2));

  int vectors = 0;
  int miscompares = 0;
  expT expQ[$];
  expT wrapQ[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  task automatic pushExp(input logic [PC_W-1:0] pc);
    expT e;
    e.pc    = pc;
    e.instr = 16'h1000 + pc;
    expQ.push_back(e);
  endtask

  // Main scoreboard: a valid slot with stall low at the edge is a new delivery
  initial begin : mon
    expT last;
    last = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n) begin
        if (id_valid) begin
          if (!stall) begin
            if (expQ.size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL unexpected_id: got pc %0h, expected no instruction", id_pc);
            end else begin
              last = expQ.pop_front();
            end
          end
          chk("id_pc",    32'(id_pc),    32'(last.pc));
          chk("id_instr", 32'(id_instr), 32'(last.instr));
          chk("opCode",   32'(opCode),   32'(last.instr[15:12]));
          chk("RAddr1",   32'(RAddr1),   32'(last.instr[7:4]));
          chk("RAddr2",   32'(RAddr2),   32'(last.instr[3:0]));
        end else begin
          chk("bubble_opCode", 32'(opCode), 32'h0000_000F);
          chk("bubble_raddr",  32'({RAddr1, RAddr2}), 32'h0);
        end
      end
    end
  end

  // Wrap-instance scoreboard: only the first deliveries after reset are scored
  initial begin : monWrap
    expT e;
    forever begin
      @(posedge clk); #1;
      if (rst_n && wValid && wrapQ.size() != 0) begin
        e = wrapQ.pop_front();
        chk("wrap_id_pc",    32'(wPc),    32'(e.pc));
        chk("wrap_id_instr", 32'(wInstr), 32'(e.instr));
      end
    end
  end

  initial begin : stim
    expT w;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0; imem_ready = 1'b1;
    wStall = 1'b0; wBranch = 1'b0; wTarget = '0; wReady = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_imem_req", 32'(imem_req), 32'h0);
    chk("rst_id_valid", 32'(id_valid), 32'h0);
    chk("rst_opCode",   32'(opCode),   32'hF);
    chk("rst_raddr",    32'({RAddr1, RAddr2}), 32'h0);
    chk("rst_addr",     32'(imem_addr), 32'h0);
    chk("rst_id_pc",    32'(id_pc),    32'h0);
    chk("rst_id_instr", 32'(id_instr), 32'h0);
    chk("rst_wrap_addr", 32'(wAddr),   32'hFFFF);

    for (int a = 0; a < 5; a++) pushExp(PC_W'(a));
    w.pc = 16'hFFFF; w.instr = 16'h0FFF; wrapQ.push_back(w);
    w.pc = 16'h0000; w.instr = 16'h1000; wrapQ.push_back(w);
    rst_n = 1'b1;

    @(negedge clk); // IDLE -> REQ
    chk("first_cycle_id_valid", 32'(id_valid), 32'h0);
    chk("first_cycle_req",      32'(imem_req), 32'h1);
    @(negedge clk); // pc 0 in IF/ID
    chk("second_cycle_id_valid", 32'(id_valid), 32'h1);
    @(negedge clk); // pc 1
    @(negedge clk); // pc 2
    stall = 1'b1;
    @(negedge clk); // pc 3 captured in skid buffer
    chk("buf_req",   32'(imem_req), 32'h0);
    chk("buf_id_pc", 32'(id_pc),    32'h2);
    @(negedge clk);
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk); // pc 3 drained into IF/ID
    chk("drain_req",  32'(imem_req),  32'h1);
    chk("drain_addr", 32'(imem_addr), 32'h4);
    @(negedge clk); // pc 4
    chk("wait_addr0", 32'(imem_addr), 32'h5);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 16'h0020;
    @(negedge clk); // redirect recorded, address held
    chk("flush_on_wait", 32'(id_valid),  32'h0);
    chk("wait_addr1",    32'(imem_addr), 32'h5);
    branch_taken = 1'b0;
    @(negedge clk);
    chk("wait_addr2", 32'(imem_addr), 32'h5);
    chk("wait_req",   32'(imem_req),  32'h1);
    pushExp(16'h0020); pushExp(16'h0021);
    imem_ready = 1'b1;
    @(negedge clk); // stale pc-5 data dropped
    chk("drop_id_valid", 32'(id_valid),  32'h0);
    chk("redirect_addr", 32'(imem_addr), 32'h20);
    @(negedge clk); // 0x20
    @(negedge clk); // 0x21
    chk("pre_flush_valid", 32'(id_valid), 32'h1);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0040;
    pushExp(16'h0040); pushExp(16'h0041);
    @(negedge clk); // flush beats stall
    chk("flush_beats_stall", 32'(id_valid),  32'h0);
    chk("flush_target_addr", 32'(imem_addr), 32'h40);
    stall = 1'b0; branch_taken = 1'b0;
    @(negedge clk); // 0x40
    @(negedge clk); // 0x41
    imem_ready = 1'b0; stall = 1'b1;

    // Reset mid-wait must act before the next clock edge
    @(posedge clk); #2;
    chk("pre_reset_req",   32'(imem_req), 32'h1);
    chk("pre_reset_valid", 32'(id_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",    32'(imem_req),  32'h0);
    chk("async_rst_valid",  32'(id_valid),  32'h0);
    chk("async_rst_opCode", 32'(opCode),    32'hF);
    chk("async_rst_addr",   32'(imem_addr), 32'h0);
    @(negedge clk);
    stall = 1'b0; imem_ready = 1'b1;
    pushExp(16'h0000); pushExp(16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("expQ_drained",  32'(expQ.size()),  32'h0);
    chk("wrapQ_drained", 32'(wrapQ.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the hazard detection unit and feeds it opCode/RAddr1/RAddr2 from the ID-stage instruction. It also consumes that unit's stall output to freeze the PC and IF/ID register. It owns the PC, a ready/req instruction-memory handshake, a one-entry skid buffer for fetches that return during a stall, and branch redirect/flush.

Parameters:
PC_W, 16, PC and instruction-memory address width (word addressed; PC+1 is the next instruction)
INSTR_W, 16, instruction width (fixed field layout below requires 16)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  from hazard detection unit; freeze IF/ID and PC
branch_taken  input  1  EX-stage branch/jump resolved taken
branch_target  input  PC_W  redirect address, valid with branch_taken
imem_req  output  1  fetch request
imem_addr  output  PC_W  fetch address, equals pc_q
imem_rdata  input  INSTR_W  fetched instruction, valid when imem_req && imem_ready
imem_ready  input  1  memory accepts/returns this cycle
id_valid  output  1  IF/ID holds a real instruction
id_instr  output  INSTR_W  IF/ID instruction
id_pc  output  PC_W  address of id_instr
opCode  output  4  id_instr[15:12]; forced to 4'hF when id_valid=0
RAddr1  output  4  id_instr[7:4]; forced to 0 when id_valid=0
RAddr2  output  4  id_instr[3:0]; forced to 0 when id_valid=0

Behaviour:
- Async reset while rst_n=0:
  - pc_q=RESET_PC, state=IDLE, id_valid=0, id_instr=0, id_pc=0.
  - drop_q=0, redir_q=0, buffer empty. Outputs: imem_req=0, opCode=4'hF, RAddr1=RAddr2=0.
- Transfer: imem_req && imem_ready in the same cycle. imem_req=1 only in state REQ. imem_addr must stay stable while imem_req=1 and imem_ready=0.
- States: IDLE, REQ, BUF.
- IDLE (first cycle after reset release):
  - Next state REQ.
  - branch_taken loads pc_q=branch_target.
- REQ, no transfer:
  - branch_taken sets drop_q=1 and redir_q=branch_target; pc_q is unchanged (address is held).
  - A later branch_taken overwrites redir_q.
- REQ, transfer, priority order:
  1. branch_taken: discard rdata, pc_q=branch_target, drop_q=0.
  2. drop_q=1: discard rdata, pc_q=redir_q, drop_q=0.
  3. stall=1: buffer rdata and its PC, pc_q=pc_q+1, go to BUF.
  4. Otherwise: id_instr=rdata, id_pc=pc_q, id_valid=1, pc_q=pc_q+1.
- BUF (imem_req=0):
  - branch_taken: empty the buffer, pc_q=branch_target, go to REQ.
  - else if stall=0: move the buffer into IF/ID (id_valid=1), go to REQ.
  - else hold.
- IF/ID update priority each cycle:
  1. branch_taken: id_valid=0 (flush). Flush wins over stall.
  2. stall: hold all id_* values.
  3. A new instruction delivered (REQ transfer case 4, or BUF drain): load it.
  4. Otherwise: id_valid=0 (bubble); id_instr/id_pc keep their old values.
- pc_q+1 wraps modulo 2^PC_W; no error is raised.
- Latency: with imem_ready held high, no stall and no branch, instructions appear in IF/ID one per cycle. The instruction at address A is in IF/ID on the cycle after its transfer.
- The decoded outputs are combinational from the IF/ID register. Invalid slots present 4'hF/0/0 so the hazard unit never stalls on a bubble.
- Reset asserted mid-fetch:
  - Aborts immediately, with no pending state retained.
  - Memory may see imem_req drop without a transfer; the memory tolerates this.

Test Plan:
- Reset, then imem_ready=1 constantly, rdata=0x1000+addr -> id_valid rises 2 cycles after rst_n release, with id_pc=0,1,2,3 on consecutive cycles and opCode=4'h1.
- stall=1 for 3 cycles starting with id_pc=2 -> id_* held at pc 2, and pc 3 captured in BUF (imem_req=0). On stall release, IF/ID=pc 3 next cycle, then fetch resumes at 4.
- imem_ready=0 at pc 5, branch_taken with target 0x20 in that wait cycle -> imem_addr stays 5 until ready. The pc-5 data is discarded (id_valid=0), and the next fetch address is 0x20.
- branch_taken and stall both high, with id_valid=1 -> id_valid=0 next cycle (flush beats stall), and pc_q=target.
- RESET_PC=0xFFFF, fetch two instructions -> id_pc=0xFFFF then 0x0000 (wrap).
- rst_n pulsed low mid-wait (imem_ready=0) -> imem_req=0, id_valid=0, and opCode=4'hF immediately, before the next clock edge.
